// File: rtl/csa_pkg.sv
// Shared state encoding and beat width for the carry-select adder result accumulator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package csa_pkg;

  // Adder result width: 8-bit sum plus carry-out
  localparam int BEAT_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/csa_sat_add.sv
// Saturating W-bit adder: clamps to all-ones and flags overflow when the carry out of W bits is set.
// Latency: combinational.
// Backpressure: not applicable.
module csa_sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);

  logic [W:0] wide;

  // Add one bit wider so the carry out of the top bit decides saturation
  always_comb begin
    wide = {1'b0, a} + {1'b0, b};
    ovf  = wide[W];
    y    = wide[W] ? '1 : wide[W-1:0];
  end

endmodule

// File: rtl/csa_result_accumulator.sv
// Accumulates 9-bit {cout,sum} adder beats over a programmed burst and presents the saturated total.
// Latency: total valid 1 clock after the last accepted beat; in_ready is a registered state decode.
// Backpressure: in_ready is low outside ACCUM so beats wait upstream; DONE holds the total until out_ready.
module csa_result_accumulator
  import csa_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [7:0]       in_sum,
  input  logic             in_cout,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [LEN_W-1:0] out_beats,
  output logic             busy
);

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   len_q;

  logic [BEAT_W-1:0]  beat;
  logic [ACC_W-1:0]   beat_ext;
  logic [ACC_W-1:0]   acc_sum;
  logic               acc_sum_ovf;
  logic [LEN_W-1:0]   cnt_inc;
  logic               beat_fire;
  logic               last_beat;
  logic               start_ok;

  assign beat      = {in_cout, in_sum};
  assign beat_ext  = ACC_W'(beat);
  assign cnt_inc   = cnt + LEN_W'(1);
  // in_ready is only ever high in ACCUM, so a fired beat always belongs to the burst
  assign beat_fire = in_valid && in_ready;
  assign last_beat = beat_fire && (cnt_inc == len_q);
  assign start_ok  = (state == ST_IDLE) && start;
  assign busy      = (state != ST_IDLE);

  csa_sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (beat_ext),
    .y   (acc_sum),
    .ovf (acc_sum_ovf)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; start outside IDLE is simply not looked at
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (len != '0) ? ST_ACCUM : ST_DONE;
        end
      end
      ST_ACCUM: begin
        if (last_beat) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags registered from the next state so both are glitch-free decodes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == ST_ACCUM);
      out_valid <= (state_nxt == ST_DONE);
    end
  end

  // Running total, beat count and the result registers copied on burst completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      len_q     <= '0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_beats <= '0;
    end else if (start_ok) begin
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
      len_q <= len;
      // A zero-length burst goes straight to DONE with an empty result
      if (len == '0) begin
        out_acc   <= '0;
        out_ovf   <= 1'b0;
        out_beats <= '0;
      end
    end else if (beat_fire) begin
      acc <= acc_sum;
      ovf <= ovf | acc_sum_ovf;
      cnt <= cnt_inc;
      if (last_beat) begin
        out_acc   <= acc_sum;
        out_ovf   <= ovf | acc_sum_ovf;
        out_beats <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_csa_result_accumulator.sv
// Bench: two accumulators (24-bit and 9-bit) driven in lockstep, results checked against a scoreboard.
// Latency: checks out_valid one clock after the last beat.
// Backpressure: exercises gapped beats and a held-off consumer.
module tb_csa_result_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_sum = 8'd0;
  logic        in_cout = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [23:0] out_acc_a;
  logic [7:0]  out_beats_a;
  logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [8:0]  out_acc_b;
  logic [7:0]  out_beats_b;

  typedef struct {
    longint acc_a;
    logic   ovf_a;
    longint acc_b;
    logic   ovf_b;
    int     beats;
  } exp_t;

  exp_t   sbq[$];
  longint run_total;
  int     run_beats;
  int     tests = 0;
  int     fails = 0;

  always #5 clk = ~clk;

  csa_result_accumulator #(.ACC_W(24), .LEN_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_sum(in_sum), .in_cout(in_cout), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
    .out_ovf(out_ovf_a), .out_beats(out_beats_a), .busy(busy_a)
  );

  csa_result_accumulator #(.ACC_W(9), .LEN_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_sum(in_sum), .in_cout(in_cout), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
    .out_ovf(out_ovf_b), .out_beats(out_beats_b), .busy(busy_b)
  );

  // All drivers are called just after a negedge and return just after a negedge.
  task automatic start_burst(input int l);
    start = 1'b1;
    len   = 8'(l);
    @(negedge clk);
    start = 1'b0;
    run_total = 0;
    run_beats = 0;
  endtask

  task automatic send_beat(input logic c, input logic [7:0] s);
    int n = 0;
    in_valid = 1'b1;
    in_cout  = c;
    in_sum   = s;
    while (!in_ready_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a) begin
      fails++;
      $display("FAIL beat_accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready_a, n);
    end else begin
      @(negedge clk);
      run_total += longint'({c, s});
      run_beats++;
    end
    in_valid = 1'b0;
  endtask

  // Saturation is monotone for non-negative beats, so the clamped grand total is the expected result
  task automatic push_expected();
    exp_t e;
    e.acc_a = (run_total > 64'd16777215) ? 64'd16777215 : run_total;
    e.ovf_a = (run_total > 64'd16777215);
    e.acc_b = (run_total > 64'd511) ? 64'd511 : run_total;
    e.ovf_b = (run_total > 64'd511);
    e.beats = run_beats;
    sbq.push_back(e);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid_a && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    int   cyc;
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({out_valid_a, busy_a, in_ready_a, out_acc_a, out_ovf_a, out_beats_a,
         out_valid_b, busy_b, in_ready_b, out_acc_b, out_ovf_b, out_beats_b} !== '0) begin
      fails++;
      $display("FAIL reset_state: vld=%0b busy=%0b rdy=%0b acc=%0d ovf=%0b beats=%0d, required all 0",
               out_valid_a, busy_a, in_ready_a, out_acc_a, out_ovf_a, out_beats_a);
    end
    rst = 1'b1;
    @(negedge clk);
    // Partial burst of 40, then reset mid-ACCUM
    start_burst(3);
    send_beat(1'b0, 8'd20);
    send_beat(1'b0, 8'd20);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({out_valid_a, busy_a, in_ready_a} !== 3'b000) begin
      fails++;
      $display("FAIL reset_mid_accum: vld=%0b busy=%0b rdy=%0b, required 0 0 0", out_valid_a, busy_a, in_ready_a);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_burst(1);
    send_beat(1'b0, 8'd7);
    push_expected();
    wait_out(cyc);
    e = sbq.pop_front();
    tests++;
    if (!out_valid_a || out_acc_a !== 24'd7 || out_acc_a !== e.acc_a[23:0] || out_beats_a !== 8'd1) begin
      fails++;
      $display("FAIL reset_recover: vld=%0b acc=%0d beats=%0d, required 1 7 1", out_valid_a, out_acc_a, out_beats_a);
    end
    // Reset while DONE drops out_valid immediately and clears the result
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({out_valid_a, busy_a, out_acc_a, out_beats_a} !== '0) begin
      fails++;
      $display("FAIL reset_in_done: vld=%0b busy=%0b acc=%0d beats=%0d, required 0 0 0 0",
               out_valid_a, busy_a, out_acc_a, out_beats_a);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t e;
    int   cyc;
    start_burst(3);
    send_beat(1'b0, 8'd7);
    send_beat(1'b0, 8'd2);
    send_beat(1'b1, 8'd41);
    push_expected();
    wait_out(cyc);
    tests++;
    if (cyc !== 0 || in_ready_a !== 1'b0) begin
      fails++;
      $display("FAIL basic_latency: extra_cycles=%0d in_ready=%0b, required 0 0", cyc, in_ready_a);
    end
    e = sbq.pop_front();
    tests++;
    if ({out_acc_a, out_ovf_a, out_acc_b, out_ovf_b, out_beats_a, out_beats_b} !==
        {e.acc_a[23:0], e.ovf_a, e.acc_b[8:0], e.ovf_b, e.beats[7:0], e.beats[7:0]}) begin
      fails++;
      $display("FAIL basic_result: acc=%0d/%0d ovf=%0b/%0b beats=%0d, required %0d/%0d %0b/%0b %0d",
               out_acc_a, out_acc_b, out_ovf_a, out_ovf_b, out_beats_a, e.acc_a, e.acc_b, e.ovf_a, e.ovf_b, e.beats);
    end
    tests++;
    if (out_acc_a !== 24'd306) begin
      fails++;
      $display("FAIL basic_total: acc=%0d, required 306", out_acc_a);
    end
    take();
  endtask

  task automatic test_back_pressure();
    exp_t e;
    int   cyc;
    bit   stable = 1'b1;
    start_burst(2);
    send_beat(1'b0, 8'd100);
    repeat (3) @(negedge clk);
    send_beat(1'b0, 8'd100);
    push_expected();
    wait_out(cyc);
    e = sbq.pop_front();
    start = 1'b1;
    len   = 8'd5;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid_a || out_acc_a !== 24'd200 || out_beats_a !== 8'd2 || !busy_a) stable = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (!stable) begin
      fails++;
      $display("FAIL bp_hold: vld=%0b acc=%0d beats=%0d, required 1 200 2 for 5 cycles",
               out_valid_a, out_acc_a, out_beats_a);
    end
    tests++;
    if ({out_acc_a, out_ovf_a, out_acc_b, out_ovf_b, out_beats_a} !==
        {e.acc_a[23:0], e.ovf_a, e.acc_b[8:0], e.ovf_b, e.beats[7:0]}) begin
      fails++;
      $display("FAIL bp_result: acc=%0d/%0d beats=%0d, required %0d/%0d %0d",
               out_acc_a, out_acc_b, out_beats_a, e.acc_a, e.acc_b, e.beats);
    end
    take();
    repeat (2) @(negedge clk);
    tests++;
    if ({out_valid_a, busy_a, in_ready_a} !== 3'b000) begin
      fails++;
      $display("FAIL bp_idle_after_take: vld=%0b busy=%0b rdy=%0b, required 0 0 0", out_valid_a, busy_a, in_ready_a);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int   cyc;
    start_burst(2);
    send_beat(1'b1, 8'd255);
    send_beat(1'b0, 8'd10);
    push_expected();
    wait_out(cyc);
    e = sbq.pop_front();
    tests++;
    if ({out_acc_b, out_ovf_b} !== {9'd511, 1'b1} || {out_acc_b, out_ovf_b} !== {e.acc_b[8:0], e.ovf_b}) begin
      fails++;
      $display("FAIL sat_9bit: acc=%0d ovf=%0b, required 511 1", out_acc_b, out_ovf_b);
    end
    tests++;
    if ({out_acc_a, out_ovf_a} !== {e.acc_a[23:0], e.ovf_a}) begin
      fails++;
      $display("FAIL sat_24bit: acc=%0d ovf=%0b, required %0d %0b", out_acc_a, out_ovf_a, e.acc_a, e.ovf_a);
    end
    take();
  endtask

  task automatic test_zero_len();
    exp_t e;
    int   cyc;
    start_burst(0);
    push_expected();
    tests++;
    if (!out_valid_a || out_acc_a !== 24'd0 || out_beats_a !== 8'd0) begin
      fails++;
      $display("FAIL zero_len: vld=%0b acc=%0d beats=%0d, required 1 0 0", out_valid_a, out_acc_a, out_beats_a);
    end
    void'(sbq.pop_front());
    take();
    // start pulsed mid-burst with a different len must not disturb the burst
    start_burst(3);
    send_beat(1'b0, 8'd1);
    start = 1'b1;
    len   = 8'd1;
    @(negedge clk);
    start = 1'b0;
    send_beat(1'b0, 8'd2);
    tests++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      fails++;
      $display("FAIL ignored_start_early_done: vld=%0b rdy=%0b, required 0 1", out_valid_a, in_ready_a);
    end
    send_beat(1'b0, 8'd3);
    push_expected();
    wait_out(cyc);
    e = sbq.pop_front();
    tests++;
    if (cyc !== 0 || out_acc_a !== e.acc_a[23:0] || out_beats_a !== e.beats[7:0]) begin
      fails++;
      $display("FAIL ignored_start_result: cyc=%0d acc=%0d beats=%0d, required 0 %0d %0d",
               cyc, out_acc_a, out_beats_a, e.acc_a, e.beats);
    end
    take();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    out_ready = 1'b1;
    start_burst(1);
    send_beat(1'b0, 8'd5);
    push_expected();
    e = sbq.pop_front();
    tests++;
    if (!out_valid_a || out_acc_a !== e.acc_a[23:0]) begin
      fails++;
      $display("FAIL b2b_first: vld=%0b acc=%0d, required 1 %0d", out_valid_a, out_acc_a, e.acc_a);
    end
    @(negedge clk);
    tests++;
    if (out_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL b2b_one_cycle: vld=%0b busy=%0b, required 0 0", out_valid_a, busy_a);
    end
    start_burst(2);
    send_beat(1'b1, 8'd0);
    send_beat(1'b0, 8'd2);
    push_expected();
    wait_out(cyc);
    e = sbq.pop_front();
    tests++;
    if (out_acc_a !== e.acc_a[23:0] || out_beats_a !== e.beats[7:0] || out_acc_b !== e.acc_b[8:0]) begin
      fails++;
      $display("FAIL b2b_second: acc=%0d/%0d beats=%0d, required %0d/%0d %0d",
               out_acc_a, out_acc_b, out_beats_a, e.acc_a, e.acc_b, e.beats);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_max_burst();
    exp_t e;
    int   cyc;
    start_burst(255);
    for (int i = 0; i < 255; i++) send_beat(1'b1, 8'd255);
    push_expected();
    wait_out(cyc);
    e = sbq.pop_front();
    tests++;
    if ({out_acc_a, out_ovf_a, out_beats_a} !== {24'd130305, 1'b0, 8'd255} ||
        out_acc_a !== e.acc_a[23:0]) begin
      fails++;
      $display("FAIL max_burst_24: acc=%0d ovf=%0b beats=%0d, required 130305 0 255", out_acc_a, out_ovf_a, out_beats_a);
    end
    tests++;
    if ({out_acc_b, out_ovf_b, out_beats_b} !== {e.acc_b[8:0], e.ovf_b, e.beats[7:0]}) begin
      fails++;
      $display("FAIL max_burst_9: acc=%0d ovf=%0b beats=%0d, required %0d %0b %0d",
               out_acc_b, out_ovf_b, out_beats_b, e.acc_b, e.ovf_b, e.beats);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_saturation();
    test_zero_len();
    test_back_to_back();
    test_max_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
